// File: rtl/tc_pl_cap_acc_pkg.sv
// Shared state encoding, default widths and per-lane arithmetic for the capture accumulator.
// Build option TC_CAP_ACC_SAT_EN switches add_lane from wrap-around to saturating adds.
package tc_pl_cap_acc_pkg;

  localparam int SMP_W_DEF = 14;
  localparam int LANES_DEF = 4;
  localparam int ACC_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_ACC  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DUMP = 3'd4
  } state_t;

  // Interpret the low w bits of raw as a two's-complement value.
  function automatic logic signed [63:0] sext_lane(input logic [63:0] raw, input int w);
    logic signed [63:0] t;
    t = $signed(raw << (64 - w));
    return t >>> (64 - w);
  endfunction

  // a and b are already w-bit signed values, so the 64-bit sum is exact before clipping/wrapping.
  function automatic logic signed [63:0] add_lane(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int w, output logic ovf);
    logic signed [63:0] sum;
    sum = a + b;
`ifdef TC_CAP_ACC_SAT_EN
    begin
      logic signed [63:0] hi, lo;
      hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo  = -hi - 64'sd1;
      ovf = (sum > hi) || (sum < lo);
      if (sum > hi) return hi;
      if (sum < lo) return lo;
      return sum;
    end
`else
    ovf = 1'b0;
    return sext_lane(sum, w);
`endif
  endfunction

endpackage

// File: rtl/tc_pl_cap_acc_ram.sv
// Simple dual-port accumulation RAM: one write port, one registered read port (1-cycle latency).
module tc_pl_cap_acc_ram #(
  parameter int W  = 96,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/tc_pl_cap_data_cap_acc.sv
// Coherent-averaging capture accumulator: sums acc_times rounds per point in RAM, then streams them out.
// Define TC_CAP_ACC_SAT_EN for saturating lane adds (any clip sets err); default wraps.
module tc_pl_cap_data_cap_acc
  import tc_pl_cap_acc_pkg::*;
#(
  parameter int SMP_W = SMP_W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int PNT_W = 14,
  parameter int ACC_W = ACC_W_DEF,
  parameter int TIM_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [TIM_W-1:0]       acc_times,
  input  logic [PNT_W-1:0]       cap_points,
  output logic                   add_en,
  input  logic                   add_cmpt,
  input  logic [LANES*SMP_W-1:0] data,
  input  logic                   data_valid,
  output logic [LANES*ACC_W-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int DATA_W = LANES * SMP_W;
  localparam int RAM_W  = LANES * ACC_W;

  state_t             state, state_nx;
  logic [TIM_W-1:0]   acc_times_r, round_cnt;
  logic [PNT_W-1:0]   cap_points_r, pt_cnt, iss_cnt, out_cnt;
  logic               vld_p0;
  logic [PNT_W-1:0]   addr_p0;
  logic [DATA_W-1:0]  data_p0;
  logic [RAM_W-1:0]   ram_rd, wr_data;
  logic signed [63:0] acc_l, smp_l;
  logic               sat_hit, lane_ovf;
  logic               beat_in, beat_acc, beat_drop, acc_exit, last_round;
  logic               rd_inflight, issue, pop, last_pt, ram_re;
  logic [PNT_W-1:0]   ram_ra;
  logic [1:0]         fifo_cnt;
  logic               fifo_hd, fifo_tl;
  logic [RAM_W-1:0]   fifo_q [2];
  logic [2:0]         occ;

  assign beat_in    = (state == ST_ACC) && data_valid;
  assign beat_acc   = beat_in && (pt_cnt < cap_points_r);
  assign beat_drop  = beat_in && !(pt_cnt < cap_points_r);
  assign acc_exit   = (state == ST_ACC) && add_cmpt && !vld_p0 && !beat_acc;
  assign last_round = (round_cnt + TIM_W'(1)) == acc_times_r;
  assign busy       = (state != ST_IDLE);

  // Dump side: 2-entry skid fed by RAM reads; occupancy counts in-flight reads so nothing overflows.
  assign rd_valid = (fifo_cnt != 2'd0);
  assign rd_data  = fifo_q[fifo_hd];
  assign pop      = rd_valid && rd_ready;
  assign last_pt  = (out_cnt == cap_points_r - PNT_W'(1));
  assign occ      = {1'b0, fifo_cnt} + {2'b0, rd_inflight} - {2'b0, pop};
  assign issue    = (state == ST_DUMP) && (iss_cnt < cap_points_r) && (occ < 3'd2);
  assign ram_re   = issue || (beat_acc && (round_cnt != '0));
  assign ram_ra   = (state == ST_DUMP) ? iss_cnt : pt_cnt;

  // Stage p1: RAM read data is back, add the registered sample and write the same point.
  always_comb begin
    wr_data  = '0;
    sat_hit  = 1'b0;
    lane_ovf = 1'b0;
    acc_l    = 64'sd0;
    smp_l    = 64'sd0;
    for (int l = 0; l < LANES; l++) begin
      acc_l = (round_cnt == '0) ? 64'sd0 : sext_lane(64'(ram_rd[l*ACC_W +: ACC_W]), ACC_W);
      smp_l = sext_lane(64'(data_p0[l*SMP_W +: SMP_W]), SMP_W);
      wr_data[l*ACC_W +: ACC_W] = ACC_W'(add_lane(acc_l, smp_l, ACC_W, lane_ovf));
      sat_hit = sat_hit | lane_ovf;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start && (cap_points != '0)) state_nx = ST_ARM;
      ST_ARM:  state_nx = ST_ACC;
      ST_ACC:  if (acc_exit) state_nx = ST_GAP;
      ST_GAP:  state_nx = last_round ? ST_DUMP : ST_ARM;
      ST_DUMP: if (pop && last_pt) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Stage p0: accepted beat registered while its RAM read is in flight.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      addr_p0 <= pt_cnt;
      data_p0 <= data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      acc_times_r  <= '0;
      cap_points_r <= '0;
      round_cnt    <= '0;
      pt_cnt       <= '0;
      iss_cnt      <= '0;
      out_cnt      <= '0;
      add_en       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      vld_p0       <= 1'b0;
      rd_inflight  <= 1'b0;
      fifo_cnt     <= 2'd0;
      fifo_hd      <= 1'b0;
      fifo_tl      <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
    end else begin
      state       <= state_nx;
      done        <= 1'b0;
      vld_p0      <= beat_acc;
      rd_inflight <= issue;
      case (state)
        ST_IDLE: if (start) begin
          acc_times_r  <= (acc_times == '0) ? TIM_W'(1) : acc_times;
          cap_points_r <= cap_points;
          round_cnt    <= '0;
          err          <= (cap_points == '0);
          done         <= (cap_points == '0);
        end
        ST_ARM: begin
          add_en <= 1'b1;
          pt_cnt <= '0;
        end
        ST_ACC: begin
          if (beat_acc) pt_cnt <= pt_cnt + PNT_W'(1);
          if (beat_drop) err <= 1'b1;
          if (acc_exit) begin
            add_en <= 1'b0;
            if (pt_cnt != cap_points_r) err <= 1'b1;
          end
        end
        ST_GAP: begin
          add_en    <= !last_round;
          round_cnt <= round_cnt + TIM_W'(1);
          iss_cnt   <= '0;
          out_cnt   <= '0;
        end
        ST_DUMP: begin
          if (issue) iss_cnt <= iss_cnt + PNT_W'(1);
          if (pop) begin
            out_cnt <= out_cnt + PNT_W'(1);
            if (last_pt) done <= 1'b1;
          end
        end
        default: ;
      endcase
      if (vld_p0 && sat_hit) err <= 1'b1;
      if (rd_inflight) begin
        fifo_q[fifo_tl] <= ram_rd;
        fifo_tl         <= ~fifo_tl;
      end
      if (pop) fifo_hd <= ~fifo_hd;
      fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, pop};
    end
  end

  tc_pl_cap_acc_ram #(.W(RAM_W), .AW(PNT_W)) u_ram (
    .clk (clk),
    .we  (vld_p0),
    .wa  (addr_p0),
    .wd  (wr_data),
    .re  (ram_re),
    .ra  (ram_ra),
    .rd  (ram_rd)
  );

endmodule

// File: tb/tb_tc_pl_cap_data_cap_acc.sv
// Randomized bench for tc_pl_cap_data_cap_acc: upstream/DMA stimulus against a per-point sum model.
`timescale 1ns/1ps
module tb_tc_pl_cap_data_cap_acc;

  localparam int SMP_W  = 14;
  localparam int LANES  = 4;
  localparam int PNT_W  = 14;
  localparam int ACC_W  = 24;
  localparam int TIM_W  = 16;
  localparam int DATA_W = LANES * SMP_W;
  localparam int RAM_W  = LANES * ACC_W;
  localparam int MAXP   = 32;
  localparam longint AMAX = (longint'(1) << (ACC_W - 1)) - 1;

  logic              clk = 1'b0;
  logic              rst, start, add_cmpt, data_valid, rd_ready;
  logic [TIM_W-1:0]  acc_times;
  logic [PNT_W-1:0]  cap_points;
  logic [DATA_W-1:0] data;
  logic              add_en, rd_valid, busy, done, err;
  logic [RAM_W-1:0]  rd_data;

  int     n_vec = 0;
  int     n_bad = 0;
  longint acc_m [MAXP][LANES];

  always #5 clk = ~clk;

  tc_pl_cap_data_cap_acc #(
    .SMP_W(SMP_W), .LANES(LANES), .PNT_W(PNT_W), .ACC_W(ACC_W), .TIM_W(TIM_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .acc_times(acc_times), .cap_points(cap_points),
    .add_en(add_en), .add_cmpt(add_cmpt), .data(data), .data_valid(data_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_add_en"},   128'(add_en),   128'(0));
    check({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
    check({tag, "_rd_data"},  128'(rd_data),  128'(0));
    check({tag, "_busy"},     128'(busy),     128'(0));
    check({tag, "_done"},     128'(done),     128'(0));
    check({tag, "_err"},      128'(err),      128'(0));
  endtask

  function automatic int gen_lane(input int mode, input int pt, input int lane);
    if (mode == 0) begin
      if (lane == 0) return pt;
      if (lane == 1) return -pt;
      if (lane == 2) return 0;
      return 8191;
    end
    if (mode == 1) return -3;
    if (mode == 3) return (pt == 0) ? 8191 : -8192;
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  function automatic logic [RAM_W-1:0] exp_word(input int p);
    logic [RAM_W-1:0] w;
    longint a;
    w = '0;
    for (int l = 0; l < LANES; l++) begin
      a = acc_m[p][l];
      w[l*ACC_W +: ACC_W] = a[ACC_W-1:0];
    end
    return w;
  endfunction

  // rdy_mode: 0 always ready, 1 toggling, 2 random. rst_mid aborts round 0 with a reset pulse.
  task automatic run_job(input int at, input int cp, input int nb, input int mode,
                         input int rdy_mode, input bit poke_start, input bit rst_mid);
    int rounds, v, cyc, lows, got, dones, bubbles;
    bit err_exp, stalled, seen;
    logic [RAM_W-1:0] held;
    rounds  = (at == 0) ? 1 : at;
    err_exp = (nb > cp);
    for (int p = 0; p < MAXP; p++)
      for (int l = 0; l < LANES; l++) acc_m[p][l] = 0;
    @(negedge clk);
    acc_times  = TIM_W'(at);
    cap_points = PNT_W'(cp);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start", 128'(busy), 128'(1));
    for (int r = 0; r < rounds; r++) begin
      cyc = 0;
      while (!add_en && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("add_en_rise", 128'(add_en), 128'(1));
      @(negedge clk);
      if (poke_start && r == 0) begin
        acc_times  = TIM_W'(7);
        cap_points = PNT_W'(3);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      for (int b = 0; b < nb; b++) begin
        while ($urandom_range(0, 3) == 0) begin
          data_valid = 1'b0;
          @(negedge clk);
        end
        for (int l = 0; l < LANES; l++) begin
          v = gen_lane(mode, b, l);
          data[l*SMP_W +: SMP_W] = v[SMP_W-1:0];
          if (b < cp) begin
            acc_m[b][l] = acc_m[b][l] + longint'(v);
`ifdef TC_CAP_ACC_SAT_EN
            if (acc_m[b][l] > AMAX) begin
              acc_m[b][l] = AMAX;
              err_exp = 1'b1;
            end else if (acc_m[b][l] < -AMAX - 1) begin
              acc_m[b][l] = -AMAX - 1;
              err_exp = 1'b1;
            end
`endif
          end
        end
        data_valid = 1'b1;
        @(negedge clk);
        if (rst_mid && b == nb / 2) begin
          data_valid = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          check_reset("mid_rst");
          rst = 1'b0;
          @(negedge clk);
          return;
        end
      end
      data_valid = 1'b0;
      add_cmpt   = 1'b1;
      cyc = 0;
      while (add_en && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("add_en_fall", 128'(add_en), 128'(0));
      add_cmpt = 1'b0;
      if (r < rounds - 1) begin
        lows = 0;
        while (!add_en && lows < 10) begin
          lows++;
          @(negedge clk);
        end
        check("add_en_low_w", 128'(lows), 128'(1));
      end
    end
    got = 0; cyc = 0; dones = 0; bubbles = 0; stalled = 1'b0; seen = 1'b0; held = '0;
    rd_ready = 1'b0;
    while (got < cp && cyc < 8 * cp + 40) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("hold_vld",  128'(rd_valid), 128'(1));
        check("hold_data", 128'(rd_data),  128'(held));
      end
      if (rdy_mode == 0) rd_ready = 1'b1;
      else if (rdy_mode == 1) rd_ready = ~rd_ready;
      else rd_ready = 1'($urandom_range(0, 1));
      if (done) dones++;
      if (seen && !rd_valid) bubbles++;
      if (rd_valid) seen = 1'b1;
      if (rd_valid && rd_ready) begin
        check("point", 128'(rd_data), 128'(exp_word(got)));
        got++;
      end
      stalled = rd_valid && !rd_ready;
      held    = rd_data;
    end
    check("dump_count", 128'(got), 128'(cp));
    check("done_early", 128'(dones), 128'(0));
    if (rdy_mode == 0) check("bubbles", 128'(bubbles), 128'(0));
    @(negedge clk);
    rd_ready = 1'b0;
    check("done_pulse", 128'(done),     128'(1));
    check("busy_end",   128'(busy),     128'(0));
    check("vld_end",    128'(rd_valid), 128'(0));
    check("err_end",    128'(err),      128'(err_exp));
    @(negedge clk);
    check("done_clr",   128'(done),     128'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; acc_times = '0; cap_points = '0;
    add_cmpt = 1'b0; data = '0; data_valid = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    acc_times = TIM_W'(1); cap_points = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cap0_done", 128'(done), 128'(1));
    check("cap0_err",  128'(err),  128'(1));
    check("cap0_busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("cap0_done_clr", 128'(done), 128'(0));

    run_job(1,    8,  8,  0, 0, 1'b0, 1'b0);
    run_job(4,    16, 16, 1, 0, 1'b0, 1'b0);
    run_job(2,    12, 12, 2, 1, 1'b1, 1'b0);
    run_job(1,    8,  10, 2, 2, 1'b0, 1'b0);
    run_job(0,    3,  3,  2, 2, 1'b0, 1'b0);
    run_job(1100, 2,  2,  3, 0, 1'b0, 1'b0);
    run_job(2,    8,  8,  2, 0, 1'b0, 1'b1);
    run_job(1,    8,  8,  2, 0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      int at, cp;
      at = int'($urandom_range(1, 3));
      cp = int'($urandom_range(1, 20));
      run_job(at, cp, cp, 2, 2, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
